// File: rtl/prefill_read_gate.sv
// prefill_read_gate: holds the read side in reset until buffer occupancy reaches THRESHOLD, counts frame words, reports underruns (PREFILL_AUTO_REARM_EN: UNDERRUN rearms to FILL)
module prefill_read_gate #(
  parameter int CNT_W          = 20,
  parameter int THRESHOLD      = 512,
  parameter int FRAME_WORDS    = 307200,
  parameter int UNDERRUN_CNT_W = 8
) (
  input  logic                      ctrl_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      iValid,
  input  logic                      iFrameStart,
  input  logic                      rd_req,
  input  logic                      rd_empty,
  input  logic                      clear_err,
  output logic                      read_rstn,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          level,
  output logic [CNT_W-1:0]          fill_cnt,
  output logic                      frame_done,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, UNDERRUN} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] TH  = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] FW  = CNT_W'(FRAME_WORDS);
  state_t st, st_nx;
  logic [CNT_W-1:0] level_nx, fill_nx;
  logic ev, fd_nx, armed;
  assign state = st;
  always_comb begin
    level_nx = !enable ? '0 :
               (iValid && !rd_req && level != MAX) ? level + 1'b1 :
               (rd_req && !iValid && level != '0) ? level - 1'b1 : level;
    fill_nx = !enable ? '0 :
              iFrameStart ? CNT_W'(iValid) :
              (iValid && fill_cnt != MAX) ? fill_cnt + 1'b1 : fill_cnt;
    ev = st == RUN && rd_req && (rd_empty || level == '0);
    fd_nx = fill_nx == FW && (iFrameStart || (armed && fill_cnt == FW - 1'b1));
    st_nx = st;
    if (!enable)
      st_nx = IDLE;
    else
      case (st)
        IDLE:     st_nx = FILL;
        FILL:     st_nx = level_nx >= TH ? RUN : FILL;
        RUN:      st_nx = ev ? UNDERRUN : RUN;
`ifdef PREFILL_AUTO_REARM_EN
        UNDERRUN: st_nx = FILL;
`else
        UNDERRUN: st_nx = UNDERRUN;
`endif
        default:  st_nx = IDLE;
      endcase
  end
  always_ff @(posedge ctrl_clk or negedge reset_n)
    if (!reset_n) begin
      st           <= IDLE;
      read_rstn    <= 1'b0;
      level        <= '0;
      fill_cnt     <= '0;
      frame_done   <= 1'b0;
      armed        <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      st           <= st_nx;
      read_rstn    <= st_nx == RUN;
      level        <= level_nx;
      fill_cnt     <= fill_nx;
      frame_done   <= fd_nx;
      armed        <= iFrameStart ? !fd_nx : armed && !fd_nx;
      underrun     <= ev || (underrun && !clear_err);
      underrun_cnt <= ev ? (clear_err ? UNDERRUN_CNT_W'(1) :
                            &underrun_cnt ? underrun_cnt : underrun_cnt + 1'b1) :
                      clear_err ? '0 : underrun_cnt;
    end
endmodule

// File: tb/tb_prefill_read_gate.sv
// tb_prefill_read_gate: directed vectors against hand-computed values for prefill_read_gate
module tb_prefill_read_gate;
  logic ctrl_clk = 1'b0;
  logic reset_n, enable, iValid, iFrameStart, rd_req, rd_empty, clear_err;
  logic read_rstn, frame_done, underrun;
  logic [1:0] state;
  logic [19:0] level, fill_cnt;
  logic [1:0] underrun_cnt;
  int total = 0;
  int bad = 0;
  int pulses;
  prefill_read_gate #(
    .CNT_W(20), .THRESHOLD(4), .FRAME_WORDS(8), .UNDERRUN_CNT_W(2)
  ) dut (
    .ctrl_clk(ctrl_clk), .reset_n(reset_n), .enable(enable), .iValid(iValid),
    .iFrameStart(iFrameStart), .rd_req(rd_req), .rd_empty(rd_empty),
    .clear_err(clear_err), .read_rstn(read_rstn), .state(state), .level(level),
    .fill_cnt(fill_cnt), .frame_done(frame_done), .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );
  always #5 ctrl_clk = ~ctrl_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ctrl_clk);
    #1;
  endtask
  task automatic to_run();
    enable = 1'b0; iValid = 1'b0; rd_req = 1'b0; rd_empty = 1'b0; clear_err = 1'b0;
    step();
    enable = 1'b1;
    step();
    iValid = 1'b1;
    repeat (4) step();
    iValid = 1'b0;
    check("to_run_state", 32'(state), 32'd2);
  endtask
  task automatic event_cycle();
    rd_req = 1'b1; rd_empty = 1'b1;
    step();
    rd_req = 1'b0; rd_empty = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0; enable = 1'b0; iValid = 1'b0; iFrameStart = 1'b0;
    rd_req = 1'b0; rd_empty = 1'b0; clear_err = 1'b0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_rstn", 32'(read_rstn), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_fill", 32'(fill_cnt), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_ur", 32'(underrun), 32'd0);
    check("rst_urcnt", 32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;
    step();
    enable = 1'b1;
    step();
    check("fill_state", 32'(state), 32'd1);
    iValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("prefill_level", 32'(level), 32'(i));
      check("prefill_state", 32'(state), 32'd1);
      check("prefill_rstn", 32'(read_rstn), 32'd0);
    end
    step();
    check("run_state", 32'(state), 32'd2);
    check("run_rstn", 32'(read_rstn), 32'd1);
    check("run_level", 32'(level), 32'd4);
    rd_req = 1'b1;
    repeat (10) begin
      step();
      check("balanced_level", 32'(level), 32'd4);
    end
    check("balanced_state", 32'(state), 32'd2);
    check("balanced_ur", 32'(underrun), 32'd0);
    rd_req = 1'b0;
    iFrameStart = 1'b1;
    step();
    iFrameStart = 1'b0;
    check("frame_start_fill", 32'(fill_cnt), 32'd1);
    pulses = 0;
    repeat (7) begin
      pulses += int'(frame_done);
      step();
    end
    pulses += int'(frame_done);
    check("frame_fill8", 32'(fill_cnt), 32'd8);
    step();
    pulses += int'(frame_done);
    check("frame_fill9", 32'(fill_cnt), 32'd9);
    step();
    iValid = 1'b0;
    pulses += int'(frame_done);
    check("frame_pulses", 32'(pulses), 32'd1);
    check("frame_level", 32'(level), 32'd14);
    rd_req = 1'b1;
    repeat (14) step();
    rd_req = 1'b0;
    check("drain_level", 32'(level), 32'd0);
    check("drain_state", 32'(state), 32'd2);
    rd_req = 1'b1; rd_empty = 1'b1;
    repeat (5) step();
    rd_req = 1'b0; rd_empty = 1'b0;
    check("ur_level", 32'(level), 32'd0);
    check("ur_flag", 32'(underrun), 32'd1);
    check("ur_cnt", 32'(underrun_cnt), 32'd1);
    check("ur_rstn", 32'(read_rstn), 32'd0);
`ifdef PREFILL_AUTO_REARM_EN
    check("rearm_state", 32'(state), 32'd1);
    iValid = 1'b1;
    repeat (3) step();
    check("rearm_fill_state", 32'(state), 32'd1);
    step();
    iValid = 1'b0;
    check("rearm_run_state", 32'(state), 32'd2);
    check("rearm_rstn", 32'(read_rstn), 32'd1);
`else
    check("ur_state", 32'(state), 32'd3);
    step();
    check("ur_terminal", 32'(state), 32'd3);
`endif
    enable = 1'b0;
    step();
    check("dis_state", 32'(state), 32'd0);
    check("dis_level", 32'(level), 32'd0);
    check("dis_fill", 32'(fill_cnt), 32'd0);
    check("dis_ur_kept", 32'(underrun), 32'd1);
    check("dis_urcnt_kept", 32'(underrun_cnt), 32'd1);
    to_run();
    clear_err = 1'b1;
    event_cycle();
    clear_err = 1'b0;
    check("clr_ev_flag", 32'(underrun), 32'd1);
    check("clr_ev_cnt", 32'(underrun_cnt), 32'd1);
    check("clr_ev_level", 32'(level), 32'd3);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("clr_flag", 32'(underrun), 32'd0);
    check("clr_cnt", 32'(underrun_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      to_run();
      event_cycle();
      check("sat_cnt", 32'(underrun_cnt), 32'(i > 3 ? 3 : i));
      check("sat_flag", 32'(underrun), 32'd1);
    end
    to_run();
    iValid = 1'b1;
    repeat (2) step();
    iValid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd6);
    check("pre_rst_state", 32'(state), 32'd2);
    reset_n = 1'b0;
    #2;
    check("arst_state", 32'(state), 32'd0);
    check("arst_rstn", 32'(read_rstn), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_fill", 32'(fill_cnt), 32'd0);
    check("arst_done", 32'(frame_done), 32'd0);
    check("arst_ur", 32'(underrun), 32'd0);
    check("arst_urcnt", 32'(underrun_cnt), 32'd0);
    reset_n = 1'b1;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
